// File: rtl/proc_sequencer.sv
// proc_sequencer: feeds a loadable 9-bit program to the DIN/Run/Done processor, one word at a time.
module proc_sequencer #(
    parameter int         DEPTH     = 32,
    parameter int         AW        = 5,
    parameter logic [2:0] MVI_OP    = 3'b001,
    parameter logic [8:0] HALT_WORD = 9'h1FF,
    parameter int         TIMEOUT   = 15
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [8:0]    LdData,
    input  logic          Start,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Finished,
    output logic          Error
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, FINISH, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    cur, nxt;
    logic          is_mvi, past_end, adv;

    assign cur      = mem_q[pc_q];
    assign nxt      = mem_q[pc_q + AW'(1)];
    assign is_mvi   = cur[8:6] == MVI_OP;
    assign past_end = pc_q == (is_mvi ? LAST - AW'(1) : LAST);
    assign PC       = pc_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Program memory is not reset; writes are locked out while a program runs.
    always_ff @(posedge Clock) begin
        if (LdEn && !Busy) mem_q[LdAddr] <= LdData;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = '0;
        adv     = 1'b0;
        case (state_q)
            ISSUE: state_d = cur == HALT_WORD ? FINISH : (is_mvi ? IMM : WAIT);
            IMM: begin
                if (pc_q == LAST) state_d = ERR;
                else if (Done) adv = 1'b1;
                else state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (Done) adv = 1'b1;
                else if (cnt_d == CW'(TIMEOUT)) state_d = ERR;
            end
            default: begin
                if (Start) begin
                    state_d = ISSUE;
                    pc_d    = '0;
                end
            end
        endcase
        // Advancing beyond the last word ends the run; PC stays on the final instruction.
        if (adv) begin
            state_d = past_end ? FINISH : ISSUE;
            pc_d    = past_end ? pc_q : pc_q + (is_mvi ? AW'(2) : AW'(1));
        end
    end

    always_comb begin
        Run      = state_q == ISSUE && cur != HALT_WORD;
        DIN      = Run ? cur : (state_q == IMM ? nxt : '0);
        Busy     = state_q == ISSUE || state_q == IMM || state_q == WAIT;
        Finished = state_q == FINISH;
        Error    = state_q == ERR;
    end
endmodule
